// File: rtl/inst_mem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller.
// Holds the default bus widths, the error-response word and the
// controller state encoding.
package inst_mem_ctrl_pkg;

    localparam int unsigned INST_ADDR_W  = 32;            // fetch/program byte address width
    localparam int unsigned INST_W       = 32;            // instruction word width
    localparam int unsigned CNT_W        = 4;             // wait-state counter, covers 0..15
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013; // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : inst_mem_ctrl_pkg

// File: rtl/inst_mem_ctrl_if.sv
// Fetch and program-load bus between the CPU/loader and the controller.
// master: CPU fetch stage plus program loader.
// slave : instruction-memory controller.
//   req_valid/req_ready/req_addr      fetch request handshake
//   rsp_valid/rsp_ready/rsp_inst/err  fetch response handshake
//   prog_we/prog_addr/prog_data/ready program-load write port
interface inst_mem_ctrl_if
    import inst_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W,
    parameter int unsigned DATA_W = INST_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;

    modport master (
        output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err, prog_ready
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err, prog_ready
    );

endinterface : inst_mem_ctrl_if

// File: rtl/inst_mem_array.sv
// Single-port synchronous instruction RAM.
// Ports:
//   clk    system clock
//   we     write enable (writes wdata to addr)
//   re     read enable (rdata <= mem[addr], one-cycle registered read)
//   addr   word index
//   wdata  write data
//   rdata  registered read data, holds its value while re is low
// Contents and read register are not reset.
module inst_mem_array #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share one address port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule : inst_mem_array

// File: rtl/inst_mem_ctrl.sv
// Instruction-memory controller with valid/ready fetch port, configurable
// wait states, response back-pressure, program-load port and error reporting.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   fetch/response/program-load bus (slave side)
//   busy  fetch in flight (WAIT or RESP)
// A fetch to a misaligned or out-of-range address returns NOP_INST with
// rsp_err set; a program write to such an address is dropped.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int unsigned      ADDR_W     = INST_ADDR_W,
    parameter int unsigned      DATA_W     = INST_W,
    parameter int unsigned      DEPTH_LOG2 = 10,
    parameter int unsigned      WAIT_CYC   = 2,
    parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(DEF_NOP_INST)
) (
    input  logic            clk,
    input  logic            rst,
    inst_mem_ctrl_if.slave  bus,
    output logic            busy
);

    localparam logic ZERO_WAIT = (WAIT_CYC == 0);

    // Word index of a byte address
    function automatic logic [DEPTH_LOG2-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[DEPTH_LOG2+1:2];
    endfunction

    // Misaligned or beyond the last RAM word
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != '0);
    endfunction

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  err_q;
    logic                  rsp_valid_q;

    logic                  in_idle;
    logic                  fetch_fire;
    logic                  ram_we;
    logic                  ram_re;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    // Handshake decode; program writes win over fetches in IDLE
    always_comb begin
        in_idle    = (state == ST_IDLE);
        fetch_fire = in_idle && bus.req_valid && !bus.prog_we;
        ram_we     = in_idle && bus.prog_we && !addr_err(bus.prog_addr) && !rst;
        ram_re     = !rst && ((fetch_fire && ZERO_WAIT) ||
                              (state == ST_WAIT && cnt == '0));
        ram_addr   = idx_q;
        if (in_idle) begin
            ram_addr = bus.prog_we ? idx_of(bus.prog_addr) : idx_of(bus.req_addr);
        end
    end

    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.prog_data),
        .rdata (ram_rdata)
    );

    // Fetch FSM: state, wait counter and registered response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_fire) begin
                        idx_q <= idx_of(bus.req_addr);
                        err_q <= addr_err(bus.req_addr);
                        busy  <= 1'b1;
                        if (ZERO_WAIT) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYC - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // RAM read is issued in the cnt==0 cycle, data lands with RESP
                    if (cnt == '0) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Response word comes straight from the RAM read register, which holds
    // its value until the next read, so it stays stable under back-pressure.
    always_comb begin
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_err    = rsp_valid_q && err_q;
        bus.rsp_inst   = '0;
        if (rsp_valid_q) begin
            bus.rsp_inst = err_q ? NOP_INST : ram_rdata;
        end
        bus.req_ready  = in_idle && !bus.prog_we;
        bus.prog_ready = in_idle;
    end

endmodule : inst_mem_ctrl

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
Parametrised instruction-memory controller with a valid/ready fetch port.
- Sits between the CPU fetch stage and a writable instruction RAM.
- Adds configurable wait states, response back-pressure, a program-load port and out-of-range/misalignment error reporting.
- Generalises the fixed combinational ROM hookup of the minimal SOPC so later SoC tops can model slow memory.

Parameters:
ADDR_W, 32, fetch/program address width (bytes)
DATA_W, 32, instruction width
DEPTH_LOG2, 10, log2 of word count (1024 words)
WAIT_CYC, 2, extra wait states per fetch, legal 0..15
NOP_INST, 32'h00000013, word returned on error (RISC-V addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  controller accepts request this cycle
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  instruction response valid
rsp_ready  in  1  CPU consumes response
rsp_inst  out  DATA_W  fetched instruction
rsp_err  out  1  response is out-of-range or misaligned
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  program-load byte address
prog_data  in  DATA_W  program-load word
prog_ready  out  1  write accepted this cycle
busy  out  1  fetch in flight (WAIT or RESP)

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE; rsp_valid=0, rsp_inst=0, rsp_err=0, busy=0, wait counter=0.
  - RAM contents are not cleared.
- Word index = addr[DEPTH_LOG2+1:2].
- Fetch error (err) when addr[1:0]!=0 or addr[ADDR_W-1:DEPTH_LOG2+2]!=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=!prog_we. prog_ready=1.
  - prog_we has priority over a fetch in the same cycle.
  - prog_we with no error: the RAM word is written.
  - prog_we with an error: the write is silently dropped.
  - Fetch accepted on req_valid&&req_ready: latch the index and the err flag.
  - WAIT_CYC==0: go to RESP.
  - Otherwise: cnt<=WAIT_CYC-1 and go to WAIT.
- WAIT:
  - req_ready=0, prog_ready=0.
  - A prog_we in WAIT or RESP is ignored; prog_ready=0 tells the loader to retry.
  - cnt decrements each cycle; when cnt==0, go to RESP.
  - RAM read is issued on the final WAIT cycle, or the accept cycle when WAIT_CYC==0.
- RESP:
  - rsp_valid=1.
  - rsp_inst = RAM word, or NOP_INST if err.
  - rsp_err = latched err.
  - Outputs are held stable until rsp_ready=1; then go to IDLE and clear rsp_valid the next cycle.
- Latency: rsp_valid rises exactly WAIT_CYC+1 cycles after the accept edge.
- Throughput: with rsp_ready tied high, one fetch per WAIT_CYC+2 cycles.
- busy=1 in WAIT and RESP.
- A write and a fetch to the same word can never collide; writes are accepted only in IDLE.
- Reset mid-fetch:
  - Any in-flight fetch is aborted; no response is produced.
  - A RAM write in the reset cycle is dropped.
- A req_valid held high during WAIT/RESP is not accepted until the next IDLE cycle.

Decomposition:
- Shared package (defs): NOP_INST default, IDLE/WAIT/RESP state encoding, InstAddrBus/InstBus widths.
- Sub-module inst_mem_array:
  - single-port synchronous RAM, DEPTH_LOG2/DATA_W parametrised;
  - write enable, one-cycle registered read;
  - no reset on contents.

Test Plan:
1. WAIT_CYC=2: prog-load 0x00500093 at addr 0x0; fetch 0x0 accepted at cycle T -> rsp_valid at T+3, rsp_inst=0x00500093, rsp_err=0.
2. WAIT_CYC=0, rsp_ready=1: fetches 0x0,0x4,0x8 issued back-to-back -> one response every 2 cycles, in order, correct data.
3. Fetch 0x2 (misaligned) and fetch 0x1000 (beyond 1024 words) -> rsp_inst=0x00000013, rsp_err=1, both times.
4. rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_inst/rsp_err stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
5. prog_we and req_valid both high in IDLE -> write completes and req_ready=0; the fetch is accepted next cycle and returns the new word.
6. Assert rst during WAIT -> next cycle IDLE, rsp_valid=0, busy=0; no stale response; RAM contents preserved on refetch.
